iic_read_burst: RTL

- Parametrised multi-byte I2C master read engine, successor to the single-byte reader.
- Invoked by the I2C controller state machine after the address/read-command phase, with SCL currently low.
- Samples 1..MAX_BYTES bytes MSB-first and drives master ACK after each byte, NACK after the last.
- Reports each byte as it arrives, plus a packed result vector and a one-cycle done pulse.
- Timing comes from the shared SCL generator strobes; no internal clock divider.

---
 rtl/iic_read_burst.sv | 115 +++++++++++
 1 files changed

// File: rtl/iic_read_burst.sv
// iic_read_burst: multi-byte I2C master read engine with per-byte ACK and final NACK
module iic_read_burst #(
  parameter int MAX_BYTES = 4,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       byte_cnt,
  input  logic                   scl,
  input  logic                   scl_lc,
  input  logic                   scl_hc,
  input  logic                   sda,
  output logic                   sdalink,
  output logic                   sda_o,
  output logic                   busy,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic [CNT_W-1:0]       byte_idx,
  output logic [8*MAX_BYTES-1:0] rd_data,
  output logic                   done,
  output logic                   err
);
  typedef enum logic [2:0] {IDLE, DATA, ACK_DRV, ACK_HOLD, FIN} state_t;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAXB = CNT_W'(MAX_BYTES);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, idx;
  logic [2:0] bitc;
  logic [6:0] shreg;
  logic ack_seen, err_f, hc, ok, last;
  assign hc = scl_hc & scl & ~scl_lc;
  assign ok = byte_cnt != '0 && byte_cnt <= MAXB;
  assign last = idx + ONE == cnt;
  assign busy = state inside {DATA, ACK_DRV, ACK_HOLD};
  assign done = state == FIN;
  assign err = done & err_f;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = start ? (ok ? DATA : FIN) : IDLE;
      DATA:     nxt = hc && bitc == 3'd0 ? ACK_DRV : DATA;
      ACK_DRV:  nxt = scl_lc ? ACK_HOLD : ACK_DRV;
      ACK_HOLD: nxt = scl_lc && ack_seen ? (last ? FIN : DATA) : ACK_HOLD;
      default:  nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      sdalink <= 1'b0;
      sda_o <= 1'b1;
      byte_valid <= 1'b0;
      byte_data <= '0;
      byte_idx <= '0;
      rd_data <= '0;
      cnt <= '0;
      idx <= '0;
      bitc <= '0;
      shreg <= '0;
      ack_seen <= 1'b0;
      err_f <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (abort) begin
        sdalink <= 1'b0;
        sda_o <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            err_f <= ~ok;
            if (ok) begin
              cnt <= byte_cnt;
              rd_data <= '0;
              idx <= '0;
              bitc <= 3'd7;
            end
          end
          DATA: if (hc) begin
            shreg <= {shreg[5:0], sda};
            bitc <= bitc - 3'd1;
            if (bitc == 3'd0) begin
              byte_valid <= 1'b1;
              byte_data <= {shreg, sda};
              byte_idx <= idx;
              for (int k = 0; k < MAX_BYTES; k++)
                if (idx == CNT_W'(k)) rd_data[8*k +: 8] <= {shreg, sda};
            end
          end
          ACK_DRV: if (scl_lc) begin
            sdalink <= ~last;
            sda_o <= last;
            ack_seen <= 1'b0;
          end
          ACK_HOLD: begin
            if (hc) ack_seen <= 1'b1;
            if (scl_lc && ack_seen) begin
              sdalink <= 1'b0;
              sda_o <= 1'b1;
              if (!last) begin
                idx <= idx + ONE;
                bitc <= 3'd7;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
